// File: rtl/serv_trace_pkg.sv
// serv_trace_pkg: shared constants, record layout and byte view for the RVFI trace serializer.
// SERV_TRACE_MEM_EN adds the memory fields to the record and the stream.
package serv_trace_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int LEN_BASE = 15;
  localparam int LEN_MEM = 24;
`ifdef SERV_TRACE_MEM_EN
  localparam int LEN = LEN_MEM;
`else
  localparam int LEN = LEN_BASE;
`endif
  localparam int IDX_W = $clog2(LEN);
  localparam int FLAG_TRAP = 7;
  localparam int FLAG_DROP = 6;
  localparam int FLAG_MEM = 5;
  typedef struct packed {
`ifdef SERV_TRACE_MEM_EN
    logic [31:0] mem_data;
    logic [7:0]  mem_mask;
    logic [31:0] mem_addr;
`endif
    logic [31:0] rd_wdata;
    logic [31:0] insn;
    logic [31:0] pc;
    logic [7:0]  flags;
    logic [7:0]  order;
  } rec_t;
  typedef logic [LEN-1:0][7:0] rec_bytes_t;
  // Byte 0 sits in the low lane, so every field comes out little-endian.
  function automatic rec_bytes_t rec_bytes(rec_t r);
`ifdef SERV_TRACE_MEM_EN
    return {r.mem_data, r.mem_mask, r.mem_addr, r.rd_wdata, r.insn, r.pc, r.flags, r.order, SYNC_BYTE};
`else
    return {r.rd_wdata, r.insn, r.pc, r.flags, r.order, SYNC_BYTE};
`endif
  endfunction
endpackage

// File: rtl/serv_trace_fifo.sv
// serv_trace_fifo: record FIFO with async active-low reset; caller never pushes when full.
module serv_trace_fifo
  import serv_trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  rec_t                     i_data,
  output rec_t                     o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  rec_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (i_push) wr_ptr <= wr_ptr + AW'(1);
      if (i_pop) rd_ptr <= rd_ptr + AW'(1);
      if (i_push && !i_pop) o_count <= o_count + CW'(1);
      else if (!i_push && i_pop) o_count <= o_count - CW'(1);
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_push) mem[wr_ptr] <= i_data;
  end
  assign o_data = mem[rd_ptr];
  assign o_full = o_count == CW'(DEPTH);
  assign o_empty = o_count == '0;
endmodule

// File: rtl/serv_rvfi_trace.sv
// serv_rvfi_trace: captures RVFI retirements into a FIFO and streams them as framed bytes.
// Define SERV_TRACE_MEM_EN to include mem_addr, masks and mem data in each record.
module serv_rvfi_trace
  import serv_trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_rvfi_valid,
  input  logic [63:0] i_rvfi_order,
  input  logic [31:0] i_rvfi_insn,
  input  logic        i_rvfi_trap,
  input  logic [31:0] i_rvfi_pc_rdata,
  input  logic [4:0]  i_rvfi_rd_addr,
  input  logic [31:0] i_rvfi_rd_wdata,
  input  logic [31:0] i_rvfi_mem_addr,
  input  logic [3:0]  i_rvfi_mem_rmask,
  input  logic [3:0]  i_rvfi_mem_wmask,
  input  logic [31:0] i_rvfi_mem_rdata,
  input  logic [31:0] i_rvfi_mem_wdata,
  output logic [7:0]  o_tdata,
  output logic        o_tvalid,
  output logic        o_tlast,
  input  logic        i_tready,
  output logic [7:0]  o_drop_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SEND = 1'b1;
  logic state, state_nx, pend_drop, cap, push, pop, last, full, empty;
  logic [IDX_W-1:0] idx;
  logic [CW-1:0] count;
  rec_t wr_rec, head;
  rec_bytes_t bytes;
  logic unused_ok;
  assign cap = i_rvfi_valid & i_en;
  assign push = cap & ~full;
  assign last = idx == IDX_W'(LEN - 1);
  assign o_tvalid = state == ST_SEND;
  assign o_tlast = o_tvalid & last;
  assign pop = o_tvalid & i_tready & last;
  assign bytes = rec_bytes(head);
  assign o_tdata = o_tvalid ? bytes[idx] : 8'h00;
  // SEND tracks "FIFO non-empty after this edge", so a capture into an idle block streams next cycle.
  assign state_nx = pop ? ((push | (count > CW'(1))) ? ST_SEND : ST_IDLE)
                        : ((push | ~empty) ? ST_SEND : ST_IDLE);
  always_comb begin
    wr_rec = '0;
    wr_rec.order = i_rvfi_order[7:0];
    wr_rec.flags[FLAG_TRAP] = i_rvfi_trap;
    wr_rec.flags[FLAG_DROP] = pend_drop;
    wr_rec.flags[4:0] = i_rvfi_rd_addr;
    wr_rec.pc = i_rvfi_pc_rdata;
    wr_rec.insn = i_rvfi_insn;
    wr_rec.rd_wdata = (i_rvfi_rd_addr == 5'd0) ? 32'h0 : i_rvfi_rd_wdata;
`ifdef SERV_TRACE_MEM_EN
    wr_rec.flags[FLAG_MEM] = |(i_rvfi_mem_rmask | i_rvfi_mem_wmask);
    wr_rec.mem_addr = i_rvfi_mem_addr;
    wr_rec.mem_mask = {i_rvfi_mem_rmask, i_rvfi_mem_wmask};
    wr_rec.mem_data = |i_rvfi_mem_wmask ? i_rvfi_mem_wdata : i_rvfi_mem_rdata;
`endif
  end
`ifdef SERV_TRACE_MEM_EN
  assign unused_ok = ^i_rvfi_order[63:8];
`else
  assign unused_ok = ^{i_rvfi_order[63:8], i_rvfi_mem_addr, i_rvfi_mem_rmask, i_rvfi_mem_wmask,
                       i_rvfi_mem_rdata, i_rvfi_mem_wdata};
`endif
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      pend_drop  <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      if (cap && full) begin
        pend_drop <= 1'b1;
        if (o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
      end else if (push) begin
        pend_drop <= 1'b0;
      end
      if (o_tvalid && i_tready) idx <= last ? '0 : idx + IDX_W'(1);
      state <= state_nx;
    end
  end
  serv_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_pop   (pop),
    .i_data  (wr_rec),
    .o_data  (head),
    .o_full  (full),
    .o_empty (empty),
    .o_count (count)
  );
endmodule

// File: tb/tb_serv_rvfi_trace.sv
// tb_serv_rvfi_trace: randomized bench with a byte-stream reference model for serv_rvfi_trace.
module tb_serv_rvfi_trace;
  localparam int DEPTH = 4;
`ifdef SERV_TRACE_MEM_EN
  localparam int RLEN = 24;
`else
  localparam int RLEN = 15;
`endif
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, valid = 1'b0, trap = 1'b0, tready = 1'b0;
  logic [63:0] order = '0;
  logic [31:0] insn = '0, pc = '0, wdata = '0, maddr = '0, mrdata = '0, mwdata = '0;
  logic [4:0] rd = '0;
  logic [3:0] rmask = '0, wmask = '0;
  logic [7:0] tdata, drop_cnt;
  logic tvalid, tlast;
  int vectors = 0, miscompares = 0;
  logic [8:0] exp_q[$];
  logic [8:0] e;
  int nrec = 0, mdrops = 0;
  bit pend = 0, held = 0;
  logic [7:0] hd;
  logic hl;
  logic [7:0] got[$];
  logic [7:0] ref_q[$];

  serv_rvfi_trace #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_rvfi_valid(valid), .i_rvfi_order(order),
    .i_rvfi_insn(insn), .i_rvfi_trap(trap), .i_rvfi_pc_rdata(pc), .i_rvfi_rd_addr(rd),
    .i_rvfi_rd_wdata(wdata), .i_rvfi_mem_addr(maddr), .i_rvfi_mem_rmask(rmask),
    .i_rvfi_mem_wmask(wmask), .i_rvfi_mem_rdata(mrdata), .i_rvfi_mem_wdata(mwdata),
    .o_tdata(tdata), .o_tvalid(tvalid), .o_tlast(tlast), .i_tready(tready), .o_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic void model_push();
    logic [7:0] b[$];
    int mem = 0;
    logic [31:0] rdv, md;
    rdv = (rd == 0) ? 32'h0 : wdata;
`ifdef SERV_TRACE_MEM_EN
    mem = ((rmask | wmask) != 0) ? 1 : 0;
`endif
    b.push_back(8'hA5);
    b.push_back(8'(order % 256));
    b.push_back(8'(int'(trap) * 128 + int'(pend) * 64 + mem * 32 + int'(rd)));
    for (int i = 0; i < 4; i++) b.push_back(8'(pc >> (8 * i)));
    for (int i = 0; i < 4; i++) b.push_back(8'(insn >> (8 * i)));
    for (int i = 0; i < 4; i++) b.push_back(8'(rdv >> (8 * i)));
`ifdef SERV_TRACE_MEM_EN
    md = (wmask != 0) ? mwdata : mrdata;
    for (int i = 0; i < 4; i++) b.push_back(8'(maddr >> (8 * i)));
    b.push_back(8'(int'(rmask) * 16 + int'(wmask)));
    for (int i = 0; i < 4; i++) b.push_back(8'(md >> (8 * i)));
`endif
    for (int i = 0; i < b.size(); i++) exp_q.push_back({i == b.size() - 1, b[i]});
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      nrec = 0;
      mdrops = 0;
      pend = 0;
      held = 0;
    end else begin
      if (held) begin
        vectors++;
        if (tvalid !== 1'b1 || tdata !== hd || tlast !== hl) begin
          miscompares++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b, want v=1 d=%h l=%b", tvalid, tdata, tlast, hd, hl);
        end
      end
      vectors++;
      if (tvalid !== (nrec > 0)) begin
        miscompares++;
        $display("FAIL tvalid: got %b, want %b (records %0d)", tvalid, nrec > 0, nrec);
      end
      vectors++;
      if (drop_cnt !== 8'(mdrops)) begin
        miscompares++;
        $display("FAIL drop_cnt: got %0d, want %0d", drop_cnt, mdrops);
      end
      if (valid && en) begin
        if (nrec == DEPTH) begin
          if (mdrops < 255) mdrops++;
          pend = 1;
        end else begin
          model_push();
          pend = 0;
          nrec++;
        end
      end
      if (tvalid && tready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL stream_spurious: got d=%h l=%b, want nothing", tdata, tlast);
        end else begin
          e = exp_q.pop_front();
          if ({tlast, tdata} !== e) begin
            miscompares++;
            $display("FAIL stream_byte: got d=%h l=%b, want d=%h l=%b", tdata, tlast, e[7:0], e[8]);
          end
          if (e[8]) nrec--;
        end
      end
      held = tvalid && !tready;
      hd = tdata;
      hl = tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    order = {$urandom, $urandom};
    insn = $urandom;
    pc = $urandom;
    rd = 5'($urandom);
    wdata = $urandom;
    trap = 1'($urandom);
    maddr = $urandom;
    mrdata = $urandom;
    mwdata = $urandom;
    rmask = 4'($urandom);
    wmask = 4'($urandom);
  endtask

  task automatic strobe();
    valid = 1'b1;
    en = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic collect();
    got.delete();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (tvalid && tready) begin
        got.push_back(tdata);
        if (tlast) begin
          tick();
          return;
        end
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL collect_timeout: got %0d bytes, want a complete record", got.size());
    tick();
  endtask

  task automatic drain();
    valid = 1'b0;
    tready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!tvalid && exp_q.size() == 0) begin
        tick();
        return;
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL drain_timeout: got %0d pending bytes, want 0", exp_q.size());
    tick();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 8'h00 || drop_cnt !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_values: got v=%b l=%b d=%h drop=%h, want all 0", tvalid, tlast, tdata, drop_cnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] lit [15];
    lit = '{8'hA5, 8'h07, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    tready = 1'b1;
    order = 64'd7; insn = 32'h00500093; pc = 32'h100; rd = 5'd1; wdata = 32'd5; trap = 1'b0;
    rmask = 4'h0; wmask = 4'h0;
    strobe();
    vectors++;
    if (tvalid !== 1'b1 || tdata !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_latency: got v=%b d=%h, want v=1 d=a5", tvalid, tdata);
    end
    collect();
    vectors++;
    if (got.size() != RLEN) begin
      miscompares++;
      $display("FAIL single_len: got %0d, want %0d", got.size(), RLEN);
    end
    for (int i = 0; i < 15 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== lit[i]) begin
        miscompares++;
        $display("FAIL single_byte%0d: got %h, want %h", i, got[i], lit[i]);
      end
    end
  endtask

  task automatic test_rd0_en();
    tready = 1'b1;
    rand_fields();
    rd = 5'd0;
    wdata = 32'hDEADBEEF;
    strobe();
    collect();
    for (int i = 11; i < 15 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== 8'h00) begin
        miscompares++;
        $display("FAIL rd0_byte%0d: got %h, want 00", i, got[i]);
      end
    end
    valid = 1'b1;
    en = 1'b0;
    repeat (3) tick();
    valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (tvalid !== 1'b0 || drop_cnt !== 8'h00) begin
        miscompares++;
        $display("FAIL en_low: got v=%b drop=%0d, want v=0 drop=0", tvalid, drop_cnt);
      end
    end
    tick();
  endtask

  task automatic test_overflow();
    tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rand_fields();
      strobe();
    end
    valid = 1'b1;
    en = 1'b0;
    repeat (2) tick();
    valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (drop_cnt !== 8'd2) begin
      miscompares++;
      $display("FAIL overflow_drops: got %0d, want 2", drop_cnt);
    end
    tick();
    drain();
    rand_fields();
    trap = 1'b0; rd = 5'd0; rmask = 4'h0; wmask = 4'h0;
    strobe();
    collect();
    vectors++;
    if (got.size() < 3 || got[2] !== 8'h40) begin
      miscompares++;
      $display("FAIL overflow_flag: got %h, want 40", got.size() < 3 ? 8'hxx : got[2]);
    end
    strobe();
    collect();
    vectors++;
    if (got.size() < 3 || got[2] !== 8'h00) begin
      miscompares++;
      $display("FAIL overflow_flag_clear: got %h, want 00", got.size() < 3 ? 8'hxx : got[2]);
    end
  endtask

  task automatic test_stall();
    tready = 1'b1;
    rand_fields();
    strobe();
    collect();
    ref_q = got;
    strobe();
    fork
      collect();
      begin
        repeat (60) begin
          @(posedge clk);
          #1;
          tready = 1'($urandom);
        end
        tready = 1'b1;
      end
    join
    vectors++;
    if (got.size() != ref_q.size()) begin
      miscompares++;
      $display("FAIL stall_len: got %0d, want %0d", got.size(), ref_q.size());
    end
    for (int i = 0; i < got.size() && i < ref_q.size(); i++) begin
      vectors++;
      if (got[i] !== ref_q[i]) begin
        miscompares++;
        $display("FAIL stall_byte%0d: got %h, want %h", i, got[i], ref_q[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rand_fields();
      valid = 1'($urandom);
      en = $urandom_range(0, 9) != 0;
      tready = $urandom_range(0, 3) != 0;
      tick();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    tready = 1'b1;
    rand_fields();
    strobe();
    repeat (6) @(posedge clk);
    #2;
    vectors++;
    if (tdata !== pc[31:24]) begin
      miscompares++;
      $display("FAIL mid_byte6: got %h, want %h", tdata, pc[31:24]);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (tvalid !== 1'b0 || tdata !== 8'h00 || tlast !== 1'b0 || drop_cnt !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset: got v=%b d=%h l=%b drop=%0d, want all 0", tvalid, tdata, tlast, drop_cnt);
    end
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    tick();
    rand_fields();
    strobe();
    vectors++;
    if (tvalid !== 1'b1 || tdata !== 8'hA5) begin
      miscompares++;
      $display("FAIL mid_restart: got v=%b d=%h, want v=1 d=a5", tvalid, tdata);
    end
    collect();
    vectors++;
    if (got.size() != RLEN) begin
      miscompares++;
      $display("FAIL mid_len: got %0d, want %0d", got.size(), RLEN);
    end
  endtask

`ifdef SERV_TRACE_MEM_EN
  task automatic test_mem();
    logic [7:0] want [9];
    want = '{8'h00, 8'h20, 8'h00, 8'h00, 8'h03, 8'h34, 8'h12, 8'h00, 8'h00};
    tready = 1'b1;
    rand_fields();
    rmask = 4'h0; wmask = 4'h3; maddr = 32'h2000; mwdata = 32'h1234;
    strobe();
    collect();
    vectors++;
    if (got.size() != 24 || got[2][5] !== 1'b1) begin
      miscompares++;
      $display("FAIL mem_len_flag: got len=%0d, want len=24 with mem flag", got.size());
    end
    for (int i = 0; i < 9 && 15 + i < got.size(); i++) begin
      vectors++;
      if (got[15 + i] !== want[i]) begin
        miscompares++;
        $display("FAIL mem_byte%0d: got %h, want %h", 15 + i, got[15 + i], want[i]);
      end
    end
  endtask
`endif

  task automatic test_saturate();
    tready = 1'b0;
    valid = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rand_fields();
      tick();
    end
    valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (drop_cnt !== 8'hFF) begin
      miscompares++;
      $display("FAIL saturate: got %0d, want 255", drop_cnt);
    end
    tick();
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rd0_en();
    test_overflow();
    test_stall();
    test_random();
    test_reset_mid();
`ifdef SERV_TRACE_MEM_EN
    test_mem();
`endif
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
